// File: rtl/axi4_rab_pkg.sv
// Shared constants for the RAB write-side drop path.
// Holds the AXI response codes, the W/B FSM state encodings and the
// debug-state struct exported by axi4_wb_drop_sender.
package axi4_rab_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // W channel FSM encodings
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FWD  = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  // B channel FSM encodings
  localparam logic [1:0] B_IDLE = 2'd0;
  localparam logic [1:0] B_FWD  = 2'd1;
  localparam logic [1:0] B_INJ  = 2'd2;

  // Live FSM state, exposed on a port so checkers can bind to it.
  typedef struct packed {
    logic [1:0] w_state;
    logic [1:0] b_state;
  } dbg_state_t;

endpackage

// File: rtl/axi_buffer_rab.sv
// Small synchronous FIFO with valid/ready on both sides.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   data_in/valid_in/ready_out write side; ready_out = not full
//   data_out/valid_out/ready_in read side; valid_out = not empty,
//                              data_out is the current head entry
// Handshake: a transfer happens on a side exactly when valid and ready are
// both high at the rising clock edge; valid never depends on ready.
// BUFFER_DEPTH must be a power of two and at least 2.
module axi_buffer_rab #(
  parameter int DATA_WIDTH   = 4,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign ready_out = !full;
  assign valid_out = !empty;
  assign data_out  = mem[rd_ptr[AW-1:0]];

  assign push = valid_in && !full;
  assign pop  = ready_in && !empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/axi4_wb_drop_sender.sv
// Write-side drop sender for the RAB.
// Consumes one accept/drop decision per AW, forwards the W burst of an
// accepted write to the master port, sinks the W burst of a dropped write,
// and injects a SLVERR B response for every dropped write, merged with the
// master-side B channel towards the slave port.
// Ports:
//   axi4_aclk, axi4_arstn      clock, synchronous active-low reset
//   trans_*                    AW decisions (drop flag + AWID), trans_ready = FIFO not full
//   s_axi4_w*                  slave-side W (input)
//   m_axi4_w*                  master-side W (output)
//   m_axi4_b*                  master-side B (input)
//   s_axi4_b*                  slave-side B (output)
//   dbg_state                  current W and B FSM states
// Handshake: every channel is AXI valid/ready; a beat transfers when valid
// and ready are both high at a rising edge, and once valid is raised the
// payload is held until that edge.
module axi4_wb_drop_sender
  import axi4_rab_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int DEC_DEPTH      = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,

  input  logic                        trans_valid,
  input  logic                        trans_drop,
  input  logic [AXI_ID_WIDTH-1:0]     trans_id,
  output logic                        trans_ready,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,

  input  logic [AXI_ID_WIDTH-1:0]     m_axi4_bid,
  input  logic [1:0]                  m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0]   m_axi4_buser,
  input  logic                        m_axi4_bvalid,
  output logic                        m_axi4_bready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi4_bid,
  output logic [1:0]                  s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0]   s_axi4_buser,
  output logic                        s_axi4_bvalid,
  input  logic                        s_axi4_bready,

  output dbg_state_t                  dbg_state
);

  // ---------------- decision FIFO ----------------
  logic                    dec_ready;
  logic                    dec_valid;
  logic                    dec_pop;
  logic [AXI_ID_WIDTH:0]   dec_head;

  axi_buffer_rab #(
    .DATA_WIDTH   (AXI_ID_WIDTH + 1),
    .BUFFER_DEPTH (DEC_DEPTH)
  ) u_dec_fifo (
    .clk       (axi4_aclk),
    .rstn      (axi4_arstn),
    .data_in   ({trans_drop, trans_id}),
    .valid_in  (trans_valid),
    .ready_out (dec_ready),
    .data_out  (dec_head),
    .valid_out (dec_valid),
    .ready_in  (dec_pop)
  );

  // Held low for the whole reset so upstream never sees a phantom slot.
  assign trans_ready = dec_ready && axi4_arstn;

  // ---------------- B-drop FIFO ----------------
  logic                    bf_push;
  logic                    bf_ready;
  logic                    bf_valid;
  logic                    bf_pop;
  logic [AXI_ID_WIDTH-1:0] bf_head;
  logic [AXI_ID_WIDTH-1:0] w_id;

  axi_buffer_rab #(
    .DATA_WIDTH   (AXI_ID_WIDTH),
    .BUFFER_DEPTH (DEC_DEPTH)
  ) u_bdrop_fifo (
    .clk       (axi4_aclk),
    .rstn      (axi4_arstn),
    .data_in   (w_id),
    .valid_in  (bf_push),
    .ready_out (bf_ready),
    .data_out  (bf_head),
    .valid_out (bf_valid),
    .ready_in  (bf_pop)
  );

  // ---------------- W FSM ----------------
  logic [1:0] w_state;
  logic [1:0] w_state_nxt;
  logic       drop_wready;

  // The decision is only popped from W_IDLE, so each burst costs one idle
  // cycle; there is deliberately no bypass around an empty FIFO.
  assign dec_pop = (w_state == W_IDLE) && dec_valid;

  // Only the last dropped beat can stall: it must find room for its B.
  assign drop_wready = s_axi4_wlast ? bf_ready : 1'b1;

  always_comb begin
    m_axi4_wdata  = s_axi4_wdata;
    m_axi4_wstrb  = s_axi4_wstrb;
    m_axi4_wlast  = s_axi4_wlast;
    m_axi4_wuser  = s_axi4_wuser;
    m_axi4_wvalid = 1'b0;
    s_axi4_wready = 1'b0;
    bf_push       = 1'b0;
    w_state_nxt   = w_state;
    case (w_state)
      W_IDLE: begin
        if (dec_valid) w_state_nxt = dec_head[AXI_ID_WIDTH] ? W_DROP : W_FWD;
      end
      W_FWD: begin
        m_axi4_wvalid = s_axi4_wvalid;
        s_axi4_wready = m_axi4_wready;
        if (s_axi4_wvalid && m_axi4_wready && s_axi4_wlast) w_state_nxt = W_IDLE;
      end
      W_DROP: begin
        s_axi4_wready = drop_wready;
        if (s_axi4_wvalid && drop_wready && s_axi4_wlast) begin
          bf_push     = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (dec_pop) w_id <= dec_head[AXI_ID_WIDTH-1:0];
    end
  end

  // ---------------- B FSM ----------------
  logic [1:0] b_state;
  logic [1:0] b_state_nxt;

  // The source is chosen in B_IDLE and held until its handshake, which
  // keeps the slave-side payload stable while it waits for bready.
  always_comb begin
    s_axi4_bid    = m_axi4_bid;
    s_axi4_bresp  = m_axi4_bresp;
    s_axi4_buser  = m_axi4_buser;
    s_axi4_bvalid = 1'b0;
    m_axi4_bready = 1'b0;
    bf_pop        = 1'b0;
    b_state_nxt   = b_state;
    case (b_state)
      B_IDLE: begin
        if (bf_valid)           b_state_nxt = B_INJ;
        else if (m_axi4_bvalid) b_state_nxt = B_FWD;
      end
      B_FWD: begin
        s_axi4_bvalid = m_axi4_bvalid;
        m_axi4_bready = s_axi4_bready;
        if (m_axi4_bvalid && s_axi4_bready) b_state_nxt = B_IDLE;
      end
      B_INJ: begin
        s_axi4_bvalid = 1'b1;
        s_axi4_bid    = bf_head;
        s_axi4_bresp  = RESP_SLVERR;
        s_axi4_buser  = '0;
        if (s_axi4_bready) begin
          bf_pop      = 1'b1;
          b_state_nxt = B_IDLE;
        end
      end
      default: b_state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) b_state <= B_IDLE;
    else             b_state <= b_state_nxt;
  end

  assign dbg_state.w_state = w_state;
  assign dbg_state.b_state = b_state;

endmodule

// File: tb/tb_axi4_wb_drop_sender.sv
module tb_axi4_wb_drop_sender;
  import axi4_rab_pkg::*;

  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int UW    = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic axi4_aclk  = 1'b0;
  logic axi4_arstn = 1'b0;
  always #5 axi4_aclk = ~axi4_aclk;

  logic          trans_valid, trans_drop, trans_ready;
  logic [IW-1:0] trans_id;
  logic [DW-1:0] s_wdata, m_wdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic          s_wlast, s_wvalid, s_wready, m_wlast, m_wvalid, m_wready;
  logic [UW-1:0] s_wuser, m_wuser;
  logic [IW-1:0] m_bid, s_bid;
  logic [1:0]    m_bresp, s_bresp;
  logic [UW-1:0] m_buser, s_buser;
  logic          m_bvalid, m_bready, s_bvalid, s_bready;
  dbg_state_t    dbg_state;

  axi4_wb_drop_sender #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .AXI_USER_WIDTH (UW),
    .DEC_DEPTH      (DEPTH)
  ) dut (
    .axi4_aclk     (axi4_aclk),
    .axi4_arstn    (axi4_arstn),
    .trans_valid   (trans_valid),
    .trans_drop    (trans_drop),
    .trans_id      (trans_id),
    .trans_ready   (trans_ready),
    .s_axi4_wdata  (s_wdata),
    .s_axi4_wstrb  (s_wstrb),
    .s_axi4_wlast  (s_wlast),
    .s_axi4_wuser  (s_wuser),
    .s_axi4_wvalid (s_wvalid),
    .s_axi4_wready (s_wready),
    .m_axi4_wdata  (m_wdata),
    .m_axi4_wstrb  (m_wstrb),
    .m_axi4_wlast  (m_wlast),
    .m_axi4_wuser  (m_wuser),
    .m_axi4_wvalid (m_wvalid),
    .m_axi4_wready (m_wready),
    .m_axi4_bid    (m_bid),
    .m_axi4_bresp  (m_bresp),
    .m_axi4_buser  (m_buser),
    .m_axi4_bvalid (m_bvalid),
    .m_axi4_bready (m_bready),
    .s_axi4_bid    (s_bid),
    .s_axi4_bresp  (s_bresp),
    .s_axi4_buser  (s_buser),
    .s_axi4_bvalid (s_bvalid),
    .s_axi4_bready (s_bready),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  // W beat seen on master side: {user, strb, last, data}
  logic [40:0] got_w [$];
  // B seen on slave side: {id, resp, user}
  logic [9:0]  got_b [$];
  int mwvalid_cycles = 0;

  always @(posedge axi4_aclk) begin
    if (axi4_arstn) begin
      if (m_wvalid) mwvalid_cycles++;
      if (m_wvalid && m_wready) got_w.push_back({m_wuser, m_wstrb, m_wlast, m_wdata});
      if (s_bvalid && s_bready) got_b.push_back({s_bid, s_bresp, s_buser});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge axi4_aclk);
    #1;
  endtask

  task automatic idle_inputs();
    trans_valid = 0; trans_drop = 0; trans_id = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_wuser = '0; s_wvalid = 0;
    m_wready = 0;
    m_bid = '0; m_bresp = '0; m_buser = '0; m_bvalid = 0;
    s_bready = 0;
  endtask

  task automatic do_reset();
    axi4_arstn = 0;
    tick();
    tick();
    axi4_arstn = 1;
    tick();
  endtask

  task automatic push_dec(input logic drop, input logic [IW-1:0] id, output bit ok);
    trans_valid = 1; trans_drop = drop; trans_id = id;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok = trans_ready;
      tick();
    end
    trans_valid = 0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] strb,
                        input logic last, input logic [UW-1:0] user,
                        output int tries, output bit ok);
    s_wdata = d; s_wstrb = strb; s_wlast = last; s_wuser = user; s_wvalid = 1;
    ok = 0;
    tries = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      ok = s_wready;
      tries++;
      tick();
    end
    s_wvalid = 0;
  endtask

  task automatic b_master(input logic [IW-1:0] id, input logic [1:0] resp,
                          input logic [UW-1:0] user, output bit ok);
    m_bid = id; m_bresp = resp; m_buser = user; m_bvalid = 1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      ok = m_bready;
      tick();
    end
    m_bvalid = 0;
  endtask

  task automatic wait_b_count(input int n);
    for (int t = 0; t < 60 && got_b.size() < n; t++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] outs;
    axi4_arstn = 0;
    // Drive every input active so idle outputs are meaningful.
    trans_valid = 1; s_wvalid = 1; s_wlast = 1; m_wready = 1;
    m_bvalid = 1; s_bready = 1;
    #1;
    n_total++;
    if (trans_ready !== 1'b0) $display("FAIL reset_trans_ready got=%b exp=0", trans_ready);
    else n_pass++;
    tick();
    outs = {s_wready, m_wvalid, s_bvalid, m_bready};
    n_total++;
    if (outs !== 4'b0000) $display("FAIL reset_outputs got=%b exp=0000", outs);
    else n_pass++;
    n_total++;
    if (dbg_state !== {W_IDLE, B_IDLE}) $display("FAIL reset_state got=%h exp=0", dbg_state);
    else n_pass++;
    idle_inputs();
    axi4_arstn = 1;
    tick();
    n_total++;
    if (trans_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", trans_ready);
    else n_pass++;
  endtask

  task automatic test_fwd();
    bit ok, all_ok;
    int tries;
    logic [40:0] exp_w [4];
    logic [40:0] v;
    all_ok = 1;
    m_wready = 1; s_bready = 0;
    push_dec(1'b0, 4'd3, ok);
    all_ok &= ok;
    for (int i = 0; i < 4; i++) begin
      w_beat(32'hA000_0000 + i, 4'h1 << i, (i == 3), 4'h5, tries, ok);
      all_ok &= ok;
    end
    exp_w[0] = {4'h5, 4'h1, 1'b0, 32'hA000_0000};
    exp_w[1] = {4'h5, 4'h2, 1'b0, 32'hA000_0001};
    exp_w[2] = {4'h5, 4'h4, 1'b0, 32'hA000_0002};
    exp_w[3] = {4'h5, 4'h8, 1'b1, 32'hA000_0003};
    n_total++;
    if (!all_ok) $display("FAIL fwd_handshakes got=timeout exp=all beats accepted");
    else n_pass++;
    n_total++;
    if (got_w.size() != 4) $display("FAIL fwd_beat_count got=%0d exp=4", got_w.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      v = (got_w.size() > i) ? got_w[i] : 'x;
      n_total++;
      if (v !== exp_w[i]) $display("FAIL fwd_beat%0d got=%h exp=%h", i, v, exp_w[i]);
      else n_pass++;
    end
    got_w.delete();
    // Master B: first cycle the B FSM is still idle, next cycle it forwards.
    m_bid = 4'd3; m_bresp = RESP_OKAY; m_buser = 4'hC; m_bvalid = 1;
    #1;
    n_total++;
    if (s_bvalid !== 1'b0) $display("FAIL fwd_b_idle_cycle got=%b exp=0", s_bvalid);
    else n_pass++;
    tick();
    n_total++;
    if ({s_bvalid, s_bid, s_bresp, s_buser} !== {1'b1, 4'd3, 2'b00, 4'hC})
      $display("FAIL fwd_b_payload got=%b/%h/%b/%h exp=1/3/00/c", s_bvalid, s_bid, s_bresp, s_buser);
    else n_pass++;
    s_bready = 1;
    tick();
    m_bvalid = 0;
    n_total++;
    if (got_b.size() != 1 || got_b[0] !== {4'd3, 2'b00, 4'hC})
      $display("FAIL fwd_b_handshake got_n=%0d exp=1 entry {3,00,c}", got_b.size());
    else n_pass++;
    got_b.delete();
  endtask

  task automatic test_drop();
    bit ok, all_ok;
    int tries, total_tries, mw0;
    logic [9:0] v;
    all_ok = 1; total_tries = 0;
    mw0 = mwvalid_cycles;
    s_bready = 1; m_wready = 1;
    push_dec(1'b1, 4'd5, ok);
    all_ok &= ok;
    for (int i = 0; i < 8; i++) begin
      w_beat(32'hD0 + i, 4'hF, (i == 7), 4'h3, tries, ok);
      all_ok &= ok;
      total_tries += tries;
    end
    n_total++;
    if (!all_ok) $display("FAIL drop_handshakes got=timeout exp=all beats accepted");
    else n_pass++;
    // One bubble cycle before the first beat, then one cycle per beat.
    n_total++;
    if (total_tries != 9) $display("FAIL drop_wready_cycles got=%0d exp=9", total_tries);
    else n_pass++;
    n_total++;
    if (mwvalid_cycles != mw0) $display("FAIL drop_m_wvalid got=%0d cycles exp=0", mwvalid_cycles - mw0);
    else n_pass++;
    wait_b_count(1);
    v = (got_b.size() > 0) ? got_b[0] : 'x;
    n_total++;
    if (got_b.size() != 1 || v !== {4'd5, 2'b10, 4'h0})
      $display("FAIL drop_inj_b got=%h n=%0d exp=%h n=1", v, got_b.size(), {4'd5, 2'b10, 4'h0});
    else n_pass++;
    got_b.delete();
    got_w.delete();
  endtask

  task automatic test_mixed();
    bit ok, all_ok;
    int tries;
    logic [40:0] exp_w [4];
    logic [40:0] v;
    logic [9:0]  vb;
    all_ok = 1;
    m_wready = 1; s_bready = 1;
    push_dec(1'b0, 4'd1, ok); all_ok &= ok;
    push_dec(1'b1, 4'd2, ok); all_ok &= ok;
    push_dec(1'b0, 4'd3, ok); all_ok &= ok;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 2; k++) begin
        w_beat(32'h100 * (b + 1) + k, 4'hF, (k == 1), UW'(b + 1), tries, ok);
        all_ok &= ok;
      end
    exp_w[0] = {4'h1, 4'hF, 1'b0, 32'h100};
    exp_w[1] = {4'h1, 4'hF, 1'b1, 32'h101};
    exp_w[2] = {4'h3, 4'hF, 1'b0, 32'h300};
    exp_w[3] = {4'h3, 4'hF, 1'b1, 32'h301};
    n_total++;
    if (!all_ok) $display("FAIL mixed_handshakes got=timeout exp=all accepted");
    else n_pass++;
    n_total++;
    if (got_w.size() != 4) $display("FAIL mixed_beat_count got=%0d exp=4", got_w.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      v = (got_w.size() > i) ? got_w[i] : 'x;
      n_total++;
      if (v !== exp_w[i]) $display("FAIL mixed_beat%0d got=%h exp=%h", i, v, exp_w[i]);
      else n_pass++;
    end
    wait_b_count(1);
    vb = (got_b.size() > 0) ? got_b[0] : 'x;
    n_total++;
    if (vb !== {4'd2, 2'b10, 4'h0}) $display("FAIL mixed_inj_b got=%h exp=%h", vb, {4'd2, 2'b10, 4'h0});
    else n_pass++;
    got_w.delete();
    got_b.delete();
  endtask

  task automatic test_b_collision();
    bit ok;
    int tries;
    logic [9:0] v0, v1;
    s_bready = 0; m_wready = 1;
    push_dec(1'b1, 4'd6, ok);
    w_beat(32'h66, 4'hF, 1'b1, 4'h0, tries, ok);
    n_total++;
    if (!ok) $display("FAIL coll_drop_beat got=timeout exp=accepted");
    else n_pass++;
    m_bid = 4'd7; m_bresp = RESP_OKAY; m_buser = 4'h9; m_bvalid = 1;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({s_bvalid, s_bid, s_bresp, s_buser, m_bready} !== {1'b1, 4'd6, 2'b10, 4'h0, 1'b0})
        $display("FAIL coll_hold_cycle%0d got=%b/%h/%b/%h/%b exp=1/6/10/0/0",
                 c, s_bvalid, s_bid, s_bresp, s_buser, m_bready);
      else n_pass++;
      tick();
    end
    s_bready = 1;
    b_master(4'd7, RESP_OKAY, 4'h9, ok);
    n_total++;
    if (!ok) $display("FAIL coll_master_b got=timeout exp=handshake");
    else n_pass++;
    v0 = (got_b.size() > 0) ? got_b[0] : 'x;
    v1 = (got_b.size() > 1) ? got_b[1] : 'x;
    n_total++;
    if (v0 !== {4'd6, 2'b10, 4'h0}) $display("FAIL coll_first_b got=%h exp=%h", v0, {4'd6, 2'b10, 4'h0});
    else n_pass++;
    n_total++;
    if (v1 !== {4'd7, 2'b00, 4'h9}) $display("FAIL coll_second_b got=%h exp=%h", v1, {4'd7, 2'b00, 4'h9});
    else n_pass++;
    got_b.delete();
    got_w.delete();
  endtask

  task automatic test_backpressure();
    bit ok, all_ok, ready_seen;
    int tries;
    logic [9:0] v;
    all_ok = 1;
    s_bready = 0; m_wready = 1;
    // Four dropped single-beat bursts fill the B-drop FIFO.
    for (int i = 0; i < 4; i++) begin
      push_dec(1'b1, IW'(8 + i), ok); all_ok &= ok;
      w_beat(32'h80 + i, 4'hF, 1'b1, 4'h0, tries, ok); all_ok &= ok;
    end
    n_total++;
    if (!all_ok) $display("FAIL bp_fill got=timeout exp=4 drops accepted");
    else n_pass++;
    push_dec(1'b1, 4'd12, ok);
    s_wdata = 32'h8C; s_wstrb = 4'hF; s_wlast = 1; s_wuser = 4'h0; s_wvalid = 1;
    ready_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (s_wready) ready_seen = 1;
      tick();
    end
    n_total++;
    if (ready_seen !== 1'b0) $display("FAIL bp_last_stall got=wready 1 exp=wready 0");
    else n_pass++;
    n_total++;
    if (dbg_state.w_state !== W_DROP) $display("FAIL bp_w_state got=%0d exp=%0d", dbg_state.w_state, W_DROP);
    else n_pass++;
    s_bready = 1;
    w_beat(32'h8C, 4'hF, 1'b1, 4'h0, tries, ok);
    n_total++;
    if (!ok) $display("FAIL bp_release got=timeout exp=accepted");
    else n_pass++;
    wait_b_count(5);
    n_total++;
    if (got_b.size() != 5) $display("FAIL bp_b_count got=%0d exp=5", got_b.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      v = (got_b.size() > i) ? got_b[i] : 'x;
      n_total++;
      if (v !== {IW'(8 + i), 2'b10, 4'h0}) $display("FAIL bp_b%0d got=%h exp=%h", i, v, {IW'(8 + i), 2'b10, 4'h0});
      else n_pass++;
    end
    got_b.delete();
    got_w.delete();
  endtask

  task automatic test_dec_full();
    int acc;
    do_reset();
    acc = 0;
    trans_valid = 1; trans_drop = 0; trans_id = 4'd1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (trans_ready) acc++;
      tick();
    end
    trans_valid = 0;
    // The W FSM pops the first decision and then waits for W data, so the
    // FIFO takes DEPTH more before it reports full.
    n_total++;
    if (acc != DEPTH + 1) $display("FAIL decfull_accepted got=%0d exp=%0d", acc, DEPTH + 1);
    else n_pass++;
    n_total++;
    if (trans_ready !== 1'b0) $display("FAIL decfull_ready got=%b exp=0", trans_ready);
    else n_pass++;
    do_reset();
    n_total++;
    if (trans_ready !== 1'b1) $display("FAIL decfull_cleared got=%b exp=1", trans_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int tries;
    logic [3:0] outs;
    m_wready = 1; s_bready = 1;
    push_dec(1'b0, 4'd4, ok);
    w_beat(32'hE0, 4'hF, 1'b0, 4'h0, tries, ok);
    s_wdata = 32'hE1; s_wlast = 0; s_wvalid = 1;
    axi4_arstn = 0;
    tick();
    outs = {s_wready, m_wvalid, s_bvalid, m_bready};
    n_total++;
    if (outs !== 4'b0000) $display("FAIL rstmid_outputs got=%b exp=0000", outs);
    else n_pass++;
    n_total++;
    if (dbg_state !== {W_IDLE, B_IDLE}) $display("FAIL rstmid_state got=%h exp=0", dbg_state);
    else n_pass++;
    s_wvalid = 0;
    tick();
    axi4_arstn = 1;
    for (int c = 0; c < 8; c++) tick();
    n_total++;
    if (got_w.size() != 1) $display("FAIL rstmid_w_beats got=%0d exp=1", got_w.size());
    else n_pass++;
    n_total++;
    if (got_b.size() != 0) $display("FAIL rstmid_no_b got=%0d exp=0", got_b.size());
    else n_pass++;
    got_w.delete();
    got_b.delete();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fwd();
    test_drop();
    test_mixed();
    test_b_collision();
    test_backpressure();
    test_dec_full();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
